// File: rtl/ap_cam_pkg.sv
// Shared opcodes, tag-accumulation modes and FSM encoding for the AP CAM array.
package ap_cam_pkg;

  localparam logic [3:0] OP_NOP           = 4'd0;
  localparam logic [3:0] OP_WR_ROW        = 4'd1;
  localparam logic [3:0] OP_WR_COL        = 4'd2;
  localparam logic [3:0] OP_RD_ROW        = 4'd3;
  localparam logic [3:0] OP_RD_COL        = 4'd4;
  localparam logic [3:0] OP_COMPARE       = 4'd5;
  localparam logic [3:0] OP_WRITE_TAGGED  = 4'd6;
  localparam logic [3:0] OP_INVERT_TAGGED = 4'd7;
  localparam logic [3:0] OP_TAG_ALL       = 4'd8;
  localparam logic [3:0] OP_TAG_CLR       = 4'd9;
  localparam logic [3:0] OP_TAG_NEXT      = 4'd10;

  localparam logic [1:0] TM_SET = 2'd0;
  localparam logic [1:0] TM_AND = 2'd1;
  localparam logic [1:0] TM_OR  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

endpackage

// File: rtl/ap_tag_reduce.sv
// Combinational tag reductions: any-match, lowest set index and popcount.
module ap_tag_reduce #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int CNT_WIDTH      = 5
) (
  input  logic [DATA_DEPTH-1:0]     i_tag,
  output logic                      o_any,
  output logic [ADDR_WIDTH_CAM-1:0] o_first,
  output logic [CNT_WIDTH-1:0]      o_count
);

  always_comb begin
    o_any   = |i_tag;
    o_first = '0;
    o_count = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int r = DATA_DEPTH - 1; r >= 0; r--) begin
      if (i_tag[r]) o_first = ADDR_WIDTH_CAM'(r);
    end
    for (int r = 0; r < DATA_DEPTH; r++) begin
      o_count = o_count + CNT_WIDTH'(i_tag[r]);
    end
  end

endmodule

// File: rtl/ap_cam_array_ctrl.sv
// Transposable associative-processor CAM array with command handshake,
// masked compare into a tag register, tagged writes and registered reductions.
module ap_cam_array_ctrl
  import ap_cam_pkg::*;
#(
  parameter  int DATA_WIDTH     = 8,
  parameter  int DATA_DEPTH     = 16,
  parameter  int ADDR_WIDTH_CAM = 8,
  localparam int BUS_WIDTH      = (DATA_WIDTH > DATA_DEPTH) ? DATA_WIDTH : DATA_DEPTH,
  localparam int CNT_WIDTH      = $clog2(DATA_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_op,
  input  logic [ADDR_WIDTH_CAM-1:0] cmd_addr,
  input  logic [BUS_WIDTH-1:0]      cmd_data,
  input  logic [DATA_WIDTH-1:0]     key,
  input  logic [DATA_WIDTH-1:0]     mask,
  input  logic [1:0]                tag_mode,
  output logic                      rsp_valid,
  output logic [BUS_WIDTH-1:0]      rsp_data,
  output logic                      rsp_err,
  output logic [DATA_DEPTH-1:0]     tag,
  output logic                      match_any,
  output logic [ADDR_WIDTH_CAM-1:0] first_idx,
  output logic [CNT_WIDTH-1:0]      match_count
);

  logic [DATA_WIDTH-1:0]     r_word [DATA_DEPTH];
  logic [DATA_DEPTH-1:0]     r_tag;
  logic [DATA_DEPTH-1:0]     r_match;
  logic [1:0]                r_mode;
  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_ready;
  logic                      r_rsp_valid;
  logic [BUS_WIDTH-1:0]      r_rsp_data;
  logic                      r_rsp_err;
  logic                      r_any;
  logic [ADDR_WIDTH_CAM-1:0] r_first;
  logic [CNT_WIDTH-1:0]      r_count;

  logic                      w_fire;
  logic                      w_row_ok;
  logic                      w_col_ok;
  logic [DATA_WIDTH-1:0]     w_row_rd;
  logic [DATA_DEPTH-1:0]     w_col_rd;
  logic [DATA_DEPTH-1:0]     w_match;
  logic                      w_any;
  logic [ADDR_WIDTH_CAM-1:0] w_first;
  logic [CNT_WIDTH-1:0]      w_count;

  assign w_fire   = cmd_valid & r_ready;
  // One extra bit keeps the bound exact when the depth fills the address space.
  assign w_row_ok = ({1'b0, cmd_addr} < (ADDR_WIDTH_CAM + 1)'(DATA_DEPTH));
  assign w_col_ok = ({1'b0, cmd_addr} < (ADDR_WIDTH_CAM + 1)'(DATA_WIDTH));

  always_comb begin
    w_row_rd = '0;
    w_col_rd = '0;
    w_match  = '0;
    for (int r = 0; r < DATA_DEPTH; r++) begin
      if (cmd_addr == ADDR_WIDTH_CAM'(r)) w_row_rd = r_word[r];
      for (int j = 0; j < DATA_WIDTH; j++) begin
        if (cmd_addr == ADDR_WIDTH_CAM'(j)) w_col_rd[r] = r_word[r][j];
      end
      w_match[r] = &(~mask | ~(r_word[r] ^ key));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_fire && (cmd_op == OP_COMPARE)) w_state_nxt = ST_CMP;
      ST_CMP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // Compare result is captured at acceptance and folded into the tag in CMP.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      for (int r = 0; r < DATA_DEPTH; r++) r_word[r] <= '0;
      r_tag       <= '0;
      r_match     <= '0;
      r_mode      <= TM_SET;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (r_state == ST_CMP) begin
        case (r_mode)
          TM_AND:  r_tag <= r_tag & r_match;
          TM_OR:   r_tag <= r_tag | r_match;
          default: r_tag <= r_match;
        endcase
      end
      if (w_fire) begin
        case (cmd_op)
          OP_WR_ROW: begin
            if (w_row_ok) begin
              for (int r = 0; r < DATA_DEPTH; r++) begin
                if (cmd_addr == ADDR_WIDTH_CAM'(r)) r_word[r] <= cmd_data[DATA_WIDTH-1:0];
              end
            end else begin
              r_rsp_err <= 1'b1;
            end
          end
          OP_WR_COL: begin
            if (w_col_ok) begin
              for (int r = 0; r < DATA_DEPTH; r++) begin
                for (int j = 0; j < DATA_WIDTH; j++) begin
                  if (cmd_addr == ADDR_WIDTH_CAM'(j)) r_word[r][j] <= cmd_data[r];
                end
              end
            end else begin
              r_rsp_err <= 1'b1;
            end
          end
          OP_RD_ROW: begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ~w_row_ok;
            r_rsp_data  <= w_row_ok ? BUS_WIDTH'(w_row_rd) : '0;
          end
          OP_RD_COL: begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ~w_col_ok;
            r_rsp_data  <= w_col_ok ? BUS_WIDTH'(w_col_rd) : '0;
          end
          OP_COMPARE: begin
            r_match <= w_match;
            r_mode  <= tag_mode;
          end
          OP_WRITE_TAGGED: begin
            for (int r = 0; r < DATA_DEPTH; r++) begin
              if (r_tag[r]) r_word[r] <= (r_word[r] & ~mask) | (key & mask);
            end
          end
          OP_INVERT_TAGGED: begin
            for (int r = 0; r < DATA_DEPTH; r++) begin
              if (r_tag[r]) r_word[r] <= r_word[r] ^ mask;
            end
          end
          OP_TAG_ALL:  r_tag <= '1;
          OP_TAG_CLR:  r_tag <= '0;
          OP_TAG_NEXT: r_tag <= r_tag & (r_tag - 1'b1);
          default: ;
        endcase
      end
    end
  end

  ap_tag_reduce #(
    .DATA_DEPTH     (DATA_DEPTH),
    .ADDR_WIDTH_CAM (ADDR_WIDTH_CAM),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_reduce (
    .i_tag   (r_tag),
    .o_any   (w_any),
    .o_first (w_first),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_any   <= 1'b0;
      r_first <= '0;
      r_count <= '0;
    end else begin
      r_any   <= w_any;
      r_first <= w_first;
      r_count <= w_count;
    end
  end

  assign cmd_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign tag         = r_tag;
  assign match_any   = r_any;
  assign first_idx   = r_first;
  assign match_count = r_count;

endmodule

// File: tb/tb_ap_cam_array_ctrl.sv
// Directed bench for ap_cam_array_ctrl with a read-response scoreboard.
module tb_ap_cam_array_ctrl;
  import ap_cam_pkg::*;

  logic        clk;
  logic        rstIn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [7:0]  key;
  logic [7:0]  mask;
  logic [1:0]  tag_mode;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] tag;
  logic        match_any;
  logic [7:0]  first_idx;
  logic [4:0]  match_count;

  typedef struct {
    logic [15:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  ap_cam_array_ctrl #(
    .DATA_WIDTH     (8),
    .DATA_DEPTH     (16),
    .ADDR_WIDTH_CAM (8)
  ) dut (
    .clk         (clk),
    .rstIn       (rstIn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .key         (key),
    .mask        (mask),
    .tag_mode    (tag_mode),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .tag         (tag),
    .match_any   (match_any),
    .first_idx   (first_idx),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a command from a negedge, holds it until accepted, returns on the following negedge.
  task automatic send_w(input logic [3:0] op, input logic [7:0] addr, input logic [15:0] data,
                        input logic [7:0] k, input logic [7:0] m, input logic [1:0] tm,
                        output int waits);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    key       = k;
    mask      = m;
    tag_mode  = tm;
    waits     = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      chk("handshake_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] addr, input logic [15:0] data,
                      input logic [7:0] k, input logic [7:0] m, input logic [1:0] tm);
    int w;
    send_w(op, addr, data, k, m, tm, w);
  endtask

  task automatic expect_rd(input string name, input logic [15:0] d, input logic err);
    exp_t x;
    x.data = d;
    x.err  = err;
    x.name = name;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_data"}, 32'(rsp_data), 32'(e.data));
        chk({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          w;
    logic [15:0] et;
    rstIn     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_addr  = '0;
    cmd_data  = '0;
    key       = '0;
    mask      = '0;
    tag_mode  = TM_SET;

    // Power-on reset and release
    tick(2);
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    rstIn = 1'b0;
    #1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_release", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Dirty state, then reset mid-run
    send(OP_WR_ROW, 8'd5, 16'h0033, 8'h00, 8'h00, TM_SET);
    send(OP_TAG_ALL, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("rd_row5_pre", 16'h0033, 1'b0);
    send(OP_RD_ROW, 8'd5, 16'h0, 8'h00, 8'h00, TM_SET);
    #2 rstIn = 1'b1;
    #1;
    chk("rst_tag", 32'(tag), 32'd0);
    chk("rst_any", 32'(match_any), 32'd0);
    chk("rst_first", 32'(first_idx), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rstIn = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_midrun_rst", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    expect_rd("rd_row5_post_rst", 16'h0000, 1'b0);
    send(OP_RD_ROW, 8'd5, 16'h0, 8'h00, 8'h00, TM_SET);

    // Row/column transpose
    for (int r = 0; r < 8; r++) send(OP_WR_ROW, 8'(r), 16'h0001 << r, 8'h00, 8'h00, TM_SET);
    expect_rd("rd_col3", 16'h0008, 1'b0);
    send(OP_RD_COL, 8'd3, 16'h0, 8'h00, 8'h00, TM_SET);
    send(OP_WR_COL, 8'd0, 16'hFFFF, 8'h00, 8'h00, TM_SET);
    expect_rd("rd_row2", 16'h0005, 1'b0);
    send(OP_RD_ROW, 8'd2, 16'h0, 8'h00, 8'h00, TM_SET);

    // Compare and accumulation modes
    for (int j = 0; j < 8; j++) send(OP_WR_COL, 8'(j), 16'h0000, 8'h00, 8'h00, TM_SET);
    send(OP_WR_ROW, 8'd2, 16'h00A5, 8'h00, 8'h00, TM_SET);
    send(OP_WR_ROW, 8'd9, 16'h00A5, 8'h00, 8'h00, TM_SET);
    send(OP_WR_ROW, 8'd4, 16'h00A4, 8'h00, 8'h00, TM_SET);
    send(OP_COMPARE, 8'd0, 16'h0, 8'hA5, 8'hFF, TM_SET);
    tick(1);
    chk("cmp_set_tag", 32'(tag), 32'h0204);
    chk("cmp_set_count_lag", 32'(match_count), 32'd0);
    tick(1);
    chk("cmp_set_count", 32'(match_count), 32'd2);
    chk("cmp_set_first", 32'(first_idx), 32'd2);
    chk("cmp_set_any", 32'(match_any), 32'd1);
    send(OP_COMPARE, 8'd0, 16'h0, 8'h04, 8'h0F, TM_AND);
    tick(2);
    chk("cmp_and_tag", 32'(tag), 32'h0000);
    chk("cmp_and_any", 32'(match_any), 32'd0);
    send(OP_COMPARE, 8'd0, 16'h0, 8'h04, 8'h0F, TM_OR);
    tick(2);
    chk("cmp_or_tag", 32'(tag), 32'h0010);
    chk("cmp_or_first", 32'(first_idx), 32'd4);
    send(OP_COMPARE, 8'd0, 16'h0, 8'h5A, 8'h00, TM_SET);
    tick(2);
    chk("cmp_mask0_tag", 32'(tag), 32'hFFFF);
    chk("cmp_mask0_count", 32'(match_count), 32'd16);

    // Tagged writes
    send(OP_COMPARE, 8'd0, 16'h0, 8'hA5, 8'hFF, TM_SET);
    tick(2);
    send(OP_WRITE_TAGGED, 8'd0, 16'h0, 8'h0F, 8'h0F, TM_SET);
    expect_rd("wt_row2", 16'h00AF, 1'b0);
    send(OP_RD_ROW, 8'd2, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("wt_row9", 16'h00AF, 1'b0);
    send(OP_RD_ROW, 8'd9, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("wt_row4", 16'h00A4, 1'b0);
    send(OP_RD_ROW, 8'd4, 16'h0, 8'h00, 8'h00, TM_SET);
    send(OP_INVERT_TAGGED, 8'd0, 16'h0, 8'h00, 8'hF0, TM_SET);
    expect_rd("inv_row2", 16'h005F, 1'b0);
    send(OP_RD_ROW, 8'd2, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("inv_row9", 16'h005F, 1'b0);
    send(OP_RD_ROW, 8'd9, 16'h0, 8'h00, 8'h00, TM_SET);

    // Back-to-back after COMPARE
    send(OP_COMPARE, 8'd0, 16'h0, 8'h5F, 8'hFF, TM_SET);
    send_w(OP_WR_ROW, 8'd7, 16'h0077, 8'h00, 8'h00, TM_SET, w);
    chk("wr_after_cmp_waits", 32'(w), 32'd1);
    chk("cmp_5f_tag", 32'(tag), 32'h0204);
    send(OP_COMPARE, 8'd0, 16'h0, 8'hA4, 8'hFF, TM_SET);
    send(OP_WRITE_TAGGED, 8'd0, 16'h0, 8'h3C, 8'hFF, TM_SET);
    expect_rd("wt_fresh_row4", 16'h003C, 1'b0);
    send(OP_RD_ROW, 8'd4, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("wt_fresh_row2", 16'h005F, 1'b0);
    send(OP_RD_ROW, 8'd2, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("wr_held_row7", 16'h0077, 1'b0);
    send(OP_RD_ROW, 8'd7, 16'h0, 8'h00, 8'h00, TM_SET);

    // Tag iteration
    send(OP_TAG_ALL, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    tick(1);
    chk("tag_all_count", 32'(match_count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      send(OP_TAG_NEXT, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
      tick(1);
      et = 16'hFFFF << i;
      chk($sformatf("next%0d_tag", i), 32'(tag), 32'(et));
      chk($sformatf("next%0d_first", i), 32'(first_idx), (i < 16) ? 32'(i) : 32'd0);
    end
    chk("iter_end_any", 32'(match_any), 32'd0);
    chk("iter_end_count", 32'(match_count), 32'd0);
    send(OP_TAG_NEXT, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    chk("next17_tag", 32'(tag), 32'd0);
    send(OP_TAG_ALL, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    send(OP_TAG_CLR, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    chk("tag_clr", 32'(tag), 32'd0);

    // Out-of-range addresses
    send(OP_WR_ROW, 8'd16, 16'h00EE, 8'h00, 8'h00, TM_SET);
    chk("wr_oor_err", 32'(rsp_err), 32'd1);
    chk("wr_oor_valid", 32'(rsp_valid), 32'd0);
    tick(1);
    chk("wr_oor_err_pulse", 32'(rsp_err), 32'd0);
    expect_rd("oor_row0_unchanged", 16'h0000, 1'b0);
    send(OP_RD_ROW, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    send(OP_WR_COL, 8'd8, 16'hFFFF, 8'h00, 8'h00, TM_SET);
    chk("wrcol_oor_err", 32'(rsp_err), 32'd1);
    expect_rd("oor_col0_unchanged", 16'h0284, 1'b0);
    send(OP_RD_COL, 8'd0, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("rd_col8_oor", 16'h0000, 1'b1);
    send(OP_RD_COL, 8'd8, 16'h0, 8'h00, 8'h00, TM_SET);
    expect_rd("rd_row16_oor", 16'h0000, 1'b1);
    send(OP_RD_ROW, 8'd16, 16'h0, 8'h00, 8'h00, TM_SET);
    send(4'd13, 8'd0, 16'hFFFF, 8'hFF, 8'hFF, TM_SET);
    chk("undef_op_tag", 32'(tag), 32'd0);

    tick(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
